// File: rtl/aes_if_pkg.sv
// aes_if_pkg: shared constants for the AES host bus interface.
// Register map, CONFIG/STATUS/START bit positions and the FSM states.
package aes_if_pkg;

  localparam logic [3:0] ADDR_CONFIG = 4'h1;
  localparam logic [3:0] ADDR_KEY    = 4'h2;
  localparam logic [3:0] ADDR_BLOCK  = 4'h3;
  localparam logic [3:0] ADDR_STATUS = 4'h5;
  localparam logic [3:0] ADDR_START  = 4'h6;
  localparam logic [3:0] ADDR_RESULT = 4'h7;
  localparam logic [3:0] ADDR_CLEAR  = 4'h8;

  localparam int CFG_ENCDEC = 0;
  localparam int CFG_KEYLEN = 1;
  localparam int CFG_IRQ_EN = 2;

  localparam int ST_KEY_RDY = 0;
  localparam int ST_BUSY    = 1;
  localparam int ST_DONE    = 2;
  localparam int ST_ERR     = 3;

  localparam int START_INIT = 0;
  localparam int START_NEXT = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYING,
    S_READY,
    S_BUSY,
    S_DONE
  } state_t;

endpackage

// File: rtl/aes_word_pack.sv
// aes_word_pack: MSB-first word loader with a saturating counter.
// A push at the limit is dropped and flagged on ovf.
module aes_word_pack
  import aes_if_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int WIDTH  = 128,
  localparam int NW     = WIDTH / DATA_W,
  localparam int CW     = $clog2(NW + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] data,
  input  logic [CW-1:0]     limit,
  output logic [WIDTH-1:0]  word,
  output logic [CW-1:0]     count,
  output logic              ovf
);

  logic full;

  assign full = (count == limit);
  assign ovf  = push && full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word  <= '0;
      count <= '0;
    end else begin
      if (push && !full) begin
        for (int i = 0; i < NW; i++) begin
          if (count == CW'(i))
            word[WIDTH-1-i*DATA_W -: DATA_W] <= data;
        end
      end
      if (clr)
        count <= '0;
      else if (push && !full)
        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/aes_bus_if.sv
// aes_bus_if: host register interface in front of an AES core.
// Loads key/block words, sequences init/next and buffers the result.
module aes_bus_if
  import aes_if_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter bit AUTO_NEXT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              irq,
  output logic              core_encdec,
  output logic              core_keylen,
  output logic              core_init,
  output logic              core_next,
  output logic [255:0]      core_key,
  output logic [127:0]      core_block,
  input  logic              core_ready,
  input  logic              core_valid,
  input  logic [127:0]      core_result
);

  localparam int KEY_NW = 256 / DATA_W;
  localparam int BLK_NW = 128 / DATA_W;
  localparam int KCW    = $clog2(KEY_NW + 1);
  localparam int BCW    = $clog2(BLK_NW + 1);

  state_t state;

  logic cfg_encdec;
  logic cfg_keylen;
  logic cfg_irq_en;
  logic err;
  logic done;
  logic key_rdy;
  logic busy;

  logic [127:0]    result;
  logic [BCW-1:0]  res_cnt;
  logic [DATA_W-1:0] res_word;
  logic [DATA_W-1:0] rd_val;

  logic [255:0]   key_word;
  logic [127:0]   blk_word;
  logic [KCW-1:0] key_cnt;
  logic [KCW-1:0] key_lim;
  logic [BCW-1:0] blk_cnt;
  logic key_full;
  logic blk_full;
  logic key_ovf;
  logic blk_ovf;

  logic wr_cfg;
  logic wr_key;
  logic wr_blk;
  logic wr_start;
  logic wr_clr;
  logic st_init;
  logic st_next;
  logic in_flight;
  logic can_go;
  logic start_bad;
  logic ok_init;
  logic ok_next;
  logic blk_last;
  logic auto_go;
  logic go_next;
  logic rd_status;
  logic pop;
  logic pop_ok;
  logic pop_last;
  logic capture;

  assign wr_cfg   = wr_en && (addr == ADDR_CONFIG);
  assign wr_key   = wr_en && (addr == ADDR_KEY);
  assign wr_blk   = wr_en && (addr == ADDR_BLOCK);
  assign wr_start = wr_en && (addr == ADDR_START);
  assign wr_clr   = wr_en && (addr == ADDR_CLEAR);

  assign st_init = wr_data[START_INIT];
  assign st_next = wr_data[START_NEXT];

  assign key_lim  = cfg_keylen ? KCW'(KEY_NW) : KCW'(KEY_NW / 2);
  assign key_full = (key_cnt == key_lim);
  assign blk_full = (blk_cnt == BCW'(BLK_NW));

  assign in_flight = (state == S_KEYING) || (state == S_BUSY);
  assign can_go    = (state == S_READY) || (state == S_DONE);
  assign busy      = in_flight;

  assign start_bad = wr_start && (in_flight ||
                     (st_init && st_next) ||
                     (st_init && !key_full) ||
                     (st_next && (!key_rdy || !blk_full)));
  assign ok_init = wr_start && !start_bad && st_init;
  assign ok_next = wr_start && !start_bad && st_next && can_go;

  // The word that completes the block can launch the core directly.
  assign blk_last = wr_blk && (blk_cnt == BCW'(BLK_NW - 1));
  assign auto_go  = AUTO_NEXT && blk_last && key_rdy && can_go;
  assign go_next  = ok_next || auto_go;

  assign rd_status = rd_en && (addr == ADDR_STATUS);
  assign pop       = rd_en && (addr == ADDR_RESULT);
  assign pop_ok    = pop && done && (res_cnt != BCW'(BLK_NW));
  assign pop_last  = pop_ok && (res_cnt == BCW'(BLK_NW - 1));
  assign capture   = (state == S_BUSY) && core_valid && !core_next;

  aes_word_pack #(
    .DATA_W (DATA_W),
    .WIDTH  (256)
  ) u_key_pack (
    .clk   (clk),
    .rst   (rst),
    .clr   (wr_cfg || wr_clr),
    .push  (wr_key),
    .data  (wr_data),
    .limit (key_lim),
    .word  (key_word),
    .count (key_cnt),
    .ovf   (key_ovf)
  );

  aes_word_pack #(
    .DATA_W (DATA_W),
    .WIDTH  (128)
  ) u_blk_pack (
    .clk   (clk),
    .rst   (rst),
    .clr   (wr_clr || go_next),
    .push  (wr_blk),
    .data  (wr_data),
    .limit (BCW'(BLK_NW)),
    .word  (blk_word),
    .count (blk_cnt),
    .ovf   (blk_ovf)
  );

  assign core_encdec = cfg_encdec;
  assign core_keylen = cfg_keylen;
  assign core_key    = cfg_keylen ? key_word
                                  : {key_word[255:128], 128'b0};
  assign core_block  = blk_word;

  always_comb begin
    res_word = '0;
    for (int i = 0; i < BLK_NW; i++) begin
      if (res_cnt == BCW'(i))
        res_word = result[127-i*DATA_W -: DATA_W];
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      rd_status: begin
        rd_val[ST_ERR]     = err;
        rd_val[ST_DONE]    = done;
        rd_val[ST_BUSY]    = busy;
        rd_val[ST_KEY_RDY] = key_rdy;
      end
      pop_ok: rd_val = res_word;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cfg_encdec <= 1'b0;
      cfg_keylen <= 1'b0;
      cfg_irq_en <= 1'b0;
      err        <= 1'b0;
      done       <= 1'b0;
      irq        <= 1'b0;
      key_rdy    <= 1'b0;
      result     <= '0;
      res_cnt    <= '0;
      core_init  <= 1'b0;
      core_next  <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      core_init <= ok_init;
      core_next <= go_next;
      rd_valid  <= rd_en;
      rd_data   <= rd_val;

      if (wr_cfg) begin
        cfg_encdec <= wr_data[CFG_ENCDEC];
        cfg_keylen <= wr_data[CFG_KEYLEN];
        cfg_irq_en <= wr_data[CFG_IRQ_EN];
      end

      // A new fault wins over a CLEAR landing in the same cycle.
      if (key_ovf || blk_ovf || start_bad || (pop && !pop_ok))
        err <= 1'b1;
      else if (wr_clr)
        err <= 1'b0;

      if (capture) begin
        done   <= 1'b1;
        irq    <= cfg_irq_en;
        result <= core_result;
      end else if (wr_clr) begin
        done <= 1'b0;
        irq  <= 1'b0;
      end

      if (capture || wr_clr)
        res_cnt <= '0;
      else if (pop_ok)
        res_cnt <= res_cnt + 1'b1;

      if (wr_cfg || ok_init)
        key_rdy <= 1'b0;
      else if ((state == S_KEYING) && core_ready && !core_init)
        key_rdy <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (ok_init)
            state <= S_KEYING;
        end
        S_KEYING: begin
          if (core_ready && !core_init)
            state <= S_READY;
        end
        S_READY, S_DONE: begin
          if (ok_init)
            state <= S_KEYING;
          else if (go_next)
            state <= S_BUSY;
          else if ((state == S_DONE) && pop_last)
            state <= S_READY;
        end
        S_BUSY: begin
          if (capture)
            state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_bus_if.sv
// tb_aes_bus_if: directed scoreboard bench for aes_bus_if.
// Three instances: 16-bit, 8-bit with 256-bit key, 32-bit auto-next.
module tb_aes_bus_if;
  import aes_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic [3:0]  addr = 4'h0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] wr_data = 32'h0;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  localparam logic [127:0] RES = 128'h69c4e0d86b7b3045cd8a70b4c55a5ac1;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] BLK = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  logic [15:0]  rd16;
  logic         rv16, irq16, enc16, kl16, c16_init, c16_next;
  logic [255:0] key16;
  logic [127:0] blk16;
  logic         rdy16, vld16;
  logic [3:0]   kc16, bc16;

  logic [7:0]   rd8;
  logic         rv8, irq8, enc8, kl8, c8_init, c8_next;
  logic [255:0] key8;
  logic [127:0] blk8;

  logic [31:0]  rd32;
  logic         rv32, irq32, enc32, kl32, c32_init, c32_next;
  logic [255:0] key32;
  logic [127:0] blk32;
  logic         rdy32, vld32;
  logic [3:0]   kc32, bc32;

  int n_init16 = 0;
  int n_next16 = 0;

  aes_bus_if #(.DATA_W(16), .AUTO_NEXT(1'b0)) u16 (
    .clk(clk), .rst(rst), .addr(addr),
    .wr_en(wr_en && sel == 2'd0), .wr_data(wr_data[15:0]),
    .rd_en(rd_en && sel == 2'd0), .rd_data(rd16), .rd_valid(rv16),
    .irq(irq16), .core_encdec(enc16), .core_keylen(kl16),
    .core_init(c16_init), .core_next(c16_next),
    .core_key(key16), .core_block(blk16),
    .core_ready(rdy16), .core_valid(vld16), .core_result(RES)
  );

  aes_bus_if #(.DATA_W(8), .AUTO_NEXT(1'b0)) u8 (
    .clk(clk), .rst(rst), .addr(addr),
    .wr_en(wr_en && sel == 2'd1), .wr_data(wr_data[7:0]),
    .rd_en(rd_en && sel == 2'd1), .rd_data(rd8), .rd_valid(rv8),
    .irq(irq8), .core_encdec(enc8), .core_keylen(kl8),
    .core_init(c8_init), .core_next(c8_next),
    .core_key(key8), .core_block(blk8),
    .core_ready(1'b0), .core_valid(1'b0), .core_result(RES)
  );

  aes_bus_if #(.DATA_W(32), .AUTO_NEXT(1'b1)) u32 (
    .clk(clk), .rst(rst), .addr(addr),
    .wr_en(wr_en && sel == 2'd2), .wr_data(wr_data),
    .rd_en(rd_en && sel == 2'd2), .rd_data(rd32), .rd_valid(rv32),
    .irq(irq32), .core_encdec(enc32), .core_keylen(kl32),
    .core_init(c32_init), .core_next(c32_next),
    .core_key(key32), .core_block(blk32),
    .core_ready(rdy32), .core_valid(vld32), .core_result(RES)
  );

  // Core stand-ins: ready drops on init, valid 12 cycles after next.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy16 <= 1'b1; vld16 <= 1'b0; kc16 <= 4'd0; bc16 <= 4'd0;
    end else begin
      if (c16_init) begin rdy16 <= 1'b0; kc16 <= 4'd4; end
      else if (kc16 != 0) begin
        kc16 <= kc16 - 4'd1;
        if (kc16 == 4'd1) rdy16 <= 1'b1;
      end
      if (c16_next) begin vld16 <= 1'b0; bc16 <= 4'd12; end
      else if (bc16 != 0) begin
        bc16 <= bc16 - 4'd1;
        if (bc16 == 4'd1) vld16 <= 1'b1;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy32 <= 1'b1; vld32 <= 1'b0; kc32 <= 4'd0; bc32 <= 4'd0;
    end else begin
      if (c32_init) begin rdy32 <= 1'b0; kc32 <= 4'd4; end
      else if (kc32 != 0) begin
        kc32 <= kc32 - 4'd1;
        if (kc32 == 4'd1) rdy32 <= 1'b1;
      end
      if (c32_next) begin vld32 <= 1'b0; bc32 <= 4'd12; end
      else if (bc32 != 0) begin
        bc32 <= bc32 - 4'd1;
        if (bc32 == 4'd1) vld32 <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (c16_init) n_init16 <= n_init16 + 1;
    if (c16_next) n_next16 <= n_next16 + 1;
  end

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] s, input logic [3:0] a,
                    input logic [31:0] d);
    sel = s; addr = a; wr_data = d; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; addr = 4'h0;
  endtask

  task automatic rd(input logic [1:0] s, input logic [3:0] a,
                    input logic [31:0] exp, input string tag);
    logic        v;
    logic [31:0] d;
    logic [31:0] e;
    sel = s; addr = a; rd_en = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    rd_en = 1'b0; addr = 4'h0;
    v = (s == 2'd0) ? rv16 : (s == 2'd1) ? rv8 : rv32;
    d = (s == 2'd0) ? 32'(rd16) : (s == 2'd1) ? 32'(rd8) : rd32;
    e = sb.pop_front();
    chk({tag, "_vld"}, 256'(v), 256'(1));
    chk(tag, 256'(d), 256'(e));
  endtask

  initial begin
    int ni0;
    int nn0;
    logic [255:0] k8;
    logic [127:0] res;
    res = RES;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus16", {rv16, irq16, 16'(rd16)}, 0);
    chk("rst_core16", {c16_init, c16_next, enc16, kl16}, 0);
    chk("rst_key16", key16, 0);
    chk("rst_blk16", 256'(blk16), 0);
    chk("rst_d8", {c8_init, c8_next, enc8, kl8, irq8, rv8, rd8,
                   |key8, |blk8}, 0);
    chk("rst_d32", {c32_init, c32_next, enc32, kl32, irq32, rv32,
                    rd32, |key32, |blk32}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    wr(2'd0, ADDR_CONFIG, 32'h1);
    chk("cfg_enc", {enc16, kl16}, 2'b10);
    for (int i = 0; i < 8; i++)
      wr(2'd0, ADDR_KEY, {16'h0, 8'(2 * i), 8'(2 * i + 1)});
    rd(2'd0, ADDR_STATUS, 32'h0, "st_prekey");
    ni0 = n_init16;
    wr(2'd0, ADDR_START, 32'h1);
    chk("init_pulse", 256'(c16_init), 256'(1));
    repeat (8) @(posedge clk);
    #1;
    chk("init_once", 256'(n_init16 - ni0), 256'(1));
    chk("key_hi", 256'(key16[255:128]), 256'(KEY));
    chk("key_lo", 256'(key16[127:0]), 0);
    rd(2'd0, ADDR_STATUS, 32'h1, "st_keyrdy");

    for (int i = 0; i < 8; i++)
      wr(2'd0, ADDR_BLOCK,
         {16'h0, 8'(34 * i), 8'(34 * i + 17)});
    chk("block", 256'(blk16), 256'(BLK));
    nn0 = n_next16;
    wr(2'd0, ADDR_START, 32'h2);
    chk("next_pulse", 256'(c16_next), 256'(1));
    rd(2'd0, ADDR_STATUS, 32'h3, "st_busy");
    wr(2'd0, ADDR_START, 32'h2);
    chk("no_next_busy", 256'(c16_next), 0);
    rd(2'd0, ADDR_STATUS, 32'hb, "st_err_busy");
    rd(2'd0, ADDR_RESULT, 32'h0, "pop_early");
    wr(2'd0, ADDR_CLEAR, 32'h0);
    rd(2'd0, ADDR_STATUS, 32'h3, "st_clr_busy");
    repeat (12) @(posedge clk);
    #1;
    chk("next_once", 256'(n_next16 - nn0), 256'(1));
    chk("irq_off", 256'(irq16), 0);
    rd(2'd0, ADDR_STATUS, 32'h5, "st_done");
    for (int i = 0; i < 8; i++)
      rd(2'd0, ADDR_RESULT, 32'(res[127 - 16 * i -: 16]),
         $sformatf("res%0d", i));
    rd(2'd0, ADDR_RESULT, 32'h0, "pop_past");
    rd(2'd0, ADDR_STATUS, 32'hd, "st_pop_err");
    wr(2'd0, ADDR_CLEAR, 32'h0);
    rd(2'd0, ADDR_STATUS, 32'h1, "st_clr");
    wr(2'd0, ADDR_START, 32'h2);
    chk("no_next_noblk", 256'(c16_next), 0);
    rd(2'd0, ADDR_STATUS, 32'h9, "st_noblk");
    wr(2'd0, ADDR_CLEAR, 32'h0);

    wr(2'd1, ADDR_CONFIG, 32'h2);
    k8 = '0;
    for (int i = 0; i < 33; i++) begin
      wr(2'd1, ADDR_KEY, 32'(i));
      if (i < 32) k8 = {k8[247:0], 8'(i)};
    end
    rd(2'd1, ADDR_STATUS, 32'h8, "st8_ovf");
    chk("key8", key8, k8);
    chk("keylen8", 256'(kl8), 256'(1));

    wr(2'd2, ADDR_CONFIG, 32'h5);
    for (int i = 0; i < 4; i++)
      wr(2'd2, ADDR_KEY, {8'(4 * i), 8'(4 * i + 1),
                          8'(4 * i + 2), 8'(4 * i + 3)});
    wr(2'd2, ADDR_START, 32'h1);
    repeat (8) @(posedge clk);
    #1;
    rd(2'd2, ADDR_STATUS, 32'h1, "st32_keyrdy");
    for (int i = 0; i < 4; i++) begin
      wr(2'd2, ADDR_BLOCK, {8'(68 * i), 8'(68 * i + 17),
                            8'(68 * i + 34), 8'(68 * i + 51)});
      if (i == 2) chk("auto_early", 256'(c32_next), 0);
    end
    chk("auto_next", 256'(c32_next), 256'(1));
    chk("block32", 256'(blk32), 256'(BLK));
    chk("irq32_pre", 256'(irq32), 0);
    repeat (16) @(posedge clk);
    #1;
    chk("irq32", 256'(irq32), 256'(1));
    rd(2'd2, ADDR_STATUS, 32'h5, "st32_done");
    rd(2'd2, ADDR_RESULT, 32'h69c4e0d8, "res32_0");

    for (int i = 0; i < 8; i++)
      wr(2'd0, ADDR_BLOCK,
         {16'h0, 8'(34 * i), 8'(34 * i + 17)});
    wr(2'd0, ADDR_START, 32'h2);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_bus", {rv16, irq16, 16'(rd16), irq32}, 0);
    chk("abort_core", {c16_init, c16_next, enc16, kl16}, 0);
    chk("abort_key", key16, 0);
    chk("abort_blk", 256'(blk16), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd(2'd0, ADDR_STATUS, 32'h0, "st_abort");
    rd(2'd0, ADDR_RESULT, 32'h0, "res_abort");
    rd(2'd2, ADDR_STATUS, 32'h0, "st32_abort");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_bus_if.md
AES_BUS_IF -- requirements
Module: aes_bus_if

Interface
REQ-001 Parameter DATA_W, default 16, host word width; legal values 8, 16 and 32.
REQ-002 Parameter AUTO_NEXT, default 0; when 1, writing the last block word while the key is valid starts encryption or decryption.
REQ-003 Port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 Port rst, input, 1; reset is asynchronous and active-high.
REQ-005 Port addr, input, 4, register address.
REQ-006 Port wr_en, input, 1, write strobe for one cycle.
REQ-007 Port wr_data, input, DATA_W, write data.
REQ-008 Port rd_en, input, 1, read strobe for one cycle.
REQ-009 Port rd_data, output, DATA_W, read data.
REQ-010 Port rd_valid, output, 1, rd_data qualifier.
REQ-011 Port irq, output, 1, level interrupt.
REQ-012 Ports core_encdec, core_keylen, core_init and core_next, output, 1 each, to the AES core.
REQ-013 Port core_key, output, 256, key to the AES core.
REQ-014 Port core_block, output, 128, block to the AES core.
REQ-015 Ports core_ready and core_valid, input, 1 each, from the AES core.
REQ-016 Port core_result, input, 128, result from the AES core.

Function
REQ-017 Address map:
- 0x1 CONFIG, write: bit0 encdec (1 = encrypt), bit1 keylen (1 = 256-bit), bit2 irq_en.
- 0x2 KEY, write: push one key word.
- 0x3 BLOCK, write: push one block word.
- 0x5 STATUS, read: {err, done, busy, key_rdy} in bits 3:0.
- 0x6 START, write: bit0 init, bit1 next.
- 0x7 RESULT, read: pop one result word.
- 0x8 CLEAR, write: clears err, done, irq and all word counters.
- Any other address: write ignored, read returns 0.
REQ-018 Word counts: key takes 128/DATA_W words, or 256/DATA_W when keylen=1; block takes 128/DATA_W words; result returns 128/DATA_W words.
REQ-019 Key and block words fill MSB-first (word 0 lands at the top bits); a 128-bit key occupies core_key[255:128] with the low half zero.
REQ-020 A push beyond the word count is ignored and sets err; the counter saturates.
REQ-021 A CONFIG write resets the key counter and clears key_rdy.
REQ-022 FSM states and transitions:
- IDLE -> KEYING on init with a full key.
- KEYING -> READY on core_ready=1, which sets key_rdy.
- READY -> BUSY on next (or AUTO_NEXT) with a full block.
- BUSY -> DONE on core_valid=1.
- DONE -> READY on the last RESULT pop, or on a START/next, which goes to BUSY.
REQ-023 core_init and core_next are single-cycle pulses asserted the cycle after the accepted write; they are never asserted together.
REQ-024 Illegal START writes do not pulse the core and set err:
- any START in KEYING or BUSY;
- init with the key incomplete;
- next with the key not ready or the block incomplete;
- init and next set together.
REQ-025 Result capture: core_result is latched on the first cycle of core_valid in BUSY; done is set, and irq=1 if irq_en.
REQ-026 Reads: rd_valid rises 1 cycle after rd_en; a RESULT pop before done or past the last word returns 0 and sets err.
REQ-027 The block counter clears when BUSY is entered, so the next block can load during BUSY while result pops run independently.
REQ-028 A wr_en and rd_en in the same cycle are both serviced.

Reset
REQ-029 Reset values:
- all registers, counters and core_* outputs are 0;
- the FSM is in IDLE;
- rd_data, rd_valid and irq are 0.
REQ-030 Asserting rst mid-operation aborts immediately; the latched result is discarded.

Structure
REQ-031 Package aes_if_pkg holds the address constants, the CONFIG/STATUS/START bit indices and the FSM state enum.
REQ-032 Sub-module aes_word_pack, instantiated twice (key 256-bit, block 128-bit), implements the MSB-first word-shift loader with counter and overflow flag.

Verification
REQ-033 DATA_W=16: CONFIG=0x1; 8 key writes of 000102030405060708090a0b0c0d0e0f; init; core_ready=1 -> core_key[255:128] matches the key, status=0x1, one core_init pulse.
REQ-034 Block 00112233445566778899aabbccddeeff; next; core model returns 69c4e0d86b7b3045cd8a70b4c55a5ac1 -> 8 RESULT reads 0x69c4, 0xe0d8, ..., 0x5ac1, each rd_valid 1 cycle after rd_en.
REQ-035 DATA_W=8, keylen=1: 33 key writes -> the first 32 are loaded, err=1, status reads 0x8 (key_rdy=0 until init completes).
REQ-036 START=0x2 written in BUSY -> no core_next pulse, err=1; a following CLEAR -> status err=0.
REQ-037 AUTO_NEXT=1, DATA_W=32: the 4th block write with key_rdy=1 -> core_next pulses the next cycle; irq rises on core_valid when irq_en=1.
REQ-038 rst asserted in BUSY -> all outputs 0 in the same cycle and a STATUS read returns 0.
